// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and widths for the MEM stage controller and its MEM/WB register.
package mem_stage_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  // FSM encoding: IDLE waits for a MEM-stage instruction, ACCESS owns the data bus.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // One MEM/WB pipeline register entry.
  typedef struct packed {
    logic [WORD_W-1:0]     pc_next;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] writeaddr;
    logic [WORD_W-1:0]     writedata;
  } wb_fields_t;

  // A memory access whose byte address is not word aligned.
  function automatic logic is_unaligned(input logic access, input logic [1:0] addr_lsb);
    return access && (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_wb_reg.sv
// MEM/WB pipeline register. A bubble kills the register-file write and leaves
// the remaining fields untouched, so nothing downstream sees a spurious write.
module mem_stage_ctrl_wb_reg
  import mem_stage_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bubble_i,
  input  wb_fields_t fields_i,
  output wb_fields_t fields_o
);

  wb_fields_t wb_q;

  // Load a full entry, or insert a bubble by clearing only regwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else if (bubble_i) begin
      wb_q.regwrite <= 1'b0;
    end else begin
      wb_q <= fields_i;
    end
  end

  assign fields_o = wb_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs the data-memory req/ack handshake for loads and
// stores, stalls the front of the pipe while an access is outstanding, and
// feeds the MEM/WB register. Unaligned and timed-out accesses set a sticky error.
//
// state     | meaning
// ST_IDLE   | no access in flight; ALU ops retire, aligned accesses start
// ST_ACCESS | dmem_req held; waiting for ack or for the timeout to expire
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_W-1:0]     pc_next_mem,
  input  logic                  memtoreg_mem,
  input  logic                  memwrite_mem,
  input  logic                  regwrite_mem,
  input  logic [REG_ADDR_W-1:0] writeaddr_mem,
  input  logic [WORD_W-1:0]     alu_result_mem,
  input  logic [WORD_W-1:0]     store_data_mem,
  output logic                  stall_mem,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [WORD_W-1:0]     dmem_addr,
  output logic [WORD_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [WORD_W-1:0]     dmem_rdata,
  output logic [WORD_W-1:0]     pc_next_wb,
  output logic                  regwrite_wb,
  output logic [REG_ADDR_W-1:0] writeaddr_wb,
  output logic [WORD_W-1:0]     writedata_wb,
  output logic                  mem_err
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic            err_q;

  logic       access;
  logic       unaligned;
  logic       in_access;
  logic       cnt_last;
  logic       bubble_d;
  wb_fields_t wb_d;
  wb_fields_t wb_q;

  assign access    = memtoreg_mem | memwrite_mem;
  assign unaligned = is_unaligned(access, alu_result_mem[1:0]);
  assign in_access = (state_q == ST_ACCESS);
  assign cnt_last  = (cnt_q == CNT_LAST);

  // Sequencer: start aligned accesses, finish on ack, abort on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (unaligned) begin
            err_q <= 1'b1;
          end else if (access) begin
            state_q <= ST_ACCESS;
            cnt_q   <= '0;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            state_q <= ST_IDLE;
          end else if (cnt_last) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from the state register, so reset drops the
  // request immediately; the address is forced to a word boundary.
  assign dmem_req   = in_access;
  assign dmem_we    = in_access & memwrite_mem;
  assign dmem_addr  = {alu_result_mem[WORD_W-1:2], 2'b00};
  assign dmem_wdata = store_data_mem;

  // Stall is combinational so an ack releases upstream in the same cycle;
  // rst_n gates it because the IDLE term depends only on inputs.
  always_comb begin
    stall_mem = 1'b0;
    if (in_access) begin
      stall_mem = ~dmem_ack & ~cnt_last;
    end else begin
      stall_mem = access & ~unaligned;
    end
    stall_mem = stall_mem & rst_n;
  end

  // WB entry selection: retire on no-access in IDLE or on ack, bubble otherwise.
  always_comb begin
    wb_d.pc_next   = pc_next_mem;
    wb_d.regwrite  = regwrite_mem;
    wb_d.writeaddr = writeaddr_mem;
    wb_d.writedata = (in_access && memtoreg_mem) ? dmem_rdata : alu_result_mem;
    bubble_d       = in_access ? ~dmem_ack : access;
  end

  mem_stage_ctrl_wb_reg u_wb_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (bubble_d),
    .fields_i (wb_d),
    .fields_o (wb_q)
  );

  assign pc_next_wb   = wb_q.pc_next;
  assign regwrite_wb  = wb_q.regwrite;
  assign writeaddr_wb = wb_q.writeaddr;
  assign writedata_wb = wb_q.writedata;
  assign mem_err      = err_q;

endmodule
